// File: rtl/unified_mem_arbiter_if.sv
// Request/response and memory-side signal bundle for unified_mem_arbiter.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: the core's fetch and data ports plus the memory.
interface unified_mem_arbiter_if #(
    parameter int BIT_COUNT = 32,
    parameter int WORD_SIZE = 32
);
    // Fetch port
    logic                   IReq;
    logic [BIT_COUNT-1:0]   IAdr;
    logic                   IReady;
    logic                   IValid;
    logic [WORD_SIZE-1:0]   IData;

    // Data port
    logic                   DReq;
    logic                   DWrite;
    logic [WORD_SIZE/8-1:0] DByteEn;
    logic [BIT_COUNT-1:0]   DAdr;
    logic [WORD_SIZE-1:0]   DWriteData;
    logic                   DReady;
    logic                   DValid;
    logic [WORD_SIZE-1:0]   DData;

    // Memory side
    logic                   MemEn;
    logic                   MemWrite;
    logic [WORD_SIZE/8-1:0] MemByteEn;
    logic [BIT_COUNT-1:0]   MemAdr;
    logic [WORD_SIZE-1:0]   MemWriteData;
    logic [WORD_SIZE-1:0]   MemReadData;

    modport slave (
        input  IReq, IAdr,
        output IReady, IValid, IData,
        input  DReq, DWrite, DByteEn, DAdr, DWriteData,
        output DReady, DValid, DData,
        output MemEn, MemWrite, MemByteEn, MemAdr, MemWriteData,
        input  MemReadData
    );

    modport master (
        output IReq, IAdr,
        input  IReady, IValid, IData,
        output DReq, DWrite, DByteEn, DAdr, DWriteData,
        input  DReady, DValid, DData,
        input  MemEn, MemWrite, MemByteEn, MemAdr, MemWriteData,
        output MemReadData
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported unified memory between the instruction-fetch port
// and the data port. Each access is sequenced through IDLE -> ACCESS -> RESP.
// Data requests have priority. After MAX_DATA_STREAK consecutive contested
// data grants, fetch is forced to win so that it cannot starve.
module unified_mem_arbiter #(
    parameter int BIT_COUNT       = 32,
    parameter int WORD_SIZE       = 32,
    parameter int MEM_LATENCY     = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    unified_mem_arbiter_if.slave  bus
);
    localparam int BE_W     = WORD_SIZE / 8;
    localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arbState;

    arbState               state;
    logic [CNT_W-1:0]      holdCnt;
    logic [STREAK_W-1:0]   streak;
    logic                  ownerData;   // 1: the outstanding access belongs to the data port
    logic                  reqWrite;    // 1: the outstanding access is a store

    logic                  iValidQ;
    logic                  dValidQ;
    logic [WORD_SIZE-1:0]  iDataQ;
    logic [WORD_SIZE-1:0]  dDataQ;
    logic                  memEnQ;
    logic                  memWriteQ;
    logic [BE_W-1:0]       memByteEnQ;
    logic [BIT_COUNT-1:0]  memAdrQ;
    logic [WORD_SIZE-1:0]  memWriteDataQ;

    logic                  canAccept;
    logic                  fetchForced;
    logic                  grantI;
    logic                  grantD;

    // A new request can only be taken while no access is holding the memory.
    // The reset term keeps both Ready outputs low while reset is asserted.
    assign canAccept   = (state == IDLE) || (state == RESP);
    assign fetchForced = (streak == STREAK_W'(MAX_DATA_STREAK));
    assign grantI      = reset && canAccept && bus.IReq && (!bus.DReq || fetchForced);
    assign grantD      = reset && canAccept && bus.DReq && !(bus.IReq && fetchForced);

    assign bus.IReady       = grantI;
    assign bus.DReady       = grantD;
    assign bus.IValid       = iValidQ;
    assign bus.DValid       = dValidQ;
    assign bus.IData        = iDataQ;
    assign bus.DData        = dDataQ;
    assign bus.MemEn        = memEnQ;
    assign bus.MemWrite     = memWriteQ;
    assign bus.MemByteEn    = memByteEnQ;
    assign bus.MemAdr       = memAdrQ;
    assign bus.MemWriteData = memWriteDataQ;

    // Access FSM, streak counter and all registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            holdCnt       <= '0;
            streak        <= '0;
            ownerData     <= 1'b0;
            reqWrite      <= 1'b0;
            iValidQ       <= 1'b0;
            dValidQ       <= 1'b0;
            iDataQ        <= '0;
            dDataQ        <= '0;
            memEnQ        <= 1'b0;
            memWriteQ     <= 1'b0;
            memByteEnQ    <= '0;
            memAdrQ       <= '0;
            memWriteDataQ <= '0;
        end else begin
            // The Valid pulses last one cycle: they are high only in RESP.
            iValidQ <= 1'b0;
            dValidQ <= 1'b0;

            // Count contested data grants. A fetch grant, or a data grant
            // while no fetch is waiting, clears the count.
            if (grantI) begin
                streak <= '0;
            end else if (grantD) begin
                if (!bus.IReq)
                    streak <= '0;
                else if (!fetchForced)
                    streak <= streak + STREAK_W'(1);
            end

            case (state)
                ACCESS: begin
                    if (holdCnt == '0) begin
                        // The memory inputs have been stable long enough, so
                        // take the read data and hand the response to the owner.
                        if (!ownerData) begin
                            iDataQ  <= bus.MemReadData;
                            iValidQ <= 1'b1;
                        end else begin
                            if (!reqWrite)
                                dDataQ <= bus.MemReadData;
                            dValidQ <= 1'b1;
                        end
                        state         <= RESP;
                        memEnQ        <= 1'b0;
                        memWriteQ     <= 1'b0;
                        memByteEnQ    <= '0;
                        memAdrQ       <= '0;
                        memWriteDataQ <= '0;
                    end else begin
                        holdCnt <= holdCnt - CNT_W'(1);
                        // The write strobe covers only the last hold cycle.
                        memWriteQ <= ownerData && reqWrite && (holdCnt == CNT_W'(1));
                    end
                end

                default: begin
                    // IDLE or RESP: the memory is released unless a request
                    // is taken, and then it is driven for the next ACCESS.
                    state         <= IDLE;
                    memEnQ        <= 1'b0;
                    memWriteQ     <= 1'b0;
                    memByteEnQ    <= '0;
                    memAdrQ       <= '0;
                    memWriteDataQ <= '0;
                    if (grantI || grantD) begin
                        state      <= ACCESS;
                        holdCnt    <= CNT_W'(MEM_LATENCY - 1);
                        ownerData  <= grantD;
                        reqWrite   <= grantD && bus.DWrite;
                        memEnQ     <= 1'b1;
                        memWriteQ  <= grantD && bus.DWrite && (MEM_LATENCY == 1);
                        memByteEnQ <= grantD ? bus.DByteEn : '0;
                        memAdrQ    <= grantD ? bus.DAdr : bus.IAdr;
                        memWriteDataQ <= (grantD && bus.DWrite) ? bus.DWriteData : '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter. Two instances are tested:
// dut1 (MEM_LATENCY=1) and dut3 (MEM_LATENCY=3). Each instance has a small
// behavioural memory with combinational read and byte-enabled write.
// Inputs are driven on the falling edge. Outputs are sampled 1 ns later.
module tb_unified_mem_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    unified_mem_arbiter_if #(.BIT_COUNT(32), .WORD_SIZE(32)) bus1 ();
    unified_mem_arbiter_if #(.BIT_COUNT(32), .WORD_SIZE(32)) bus3 ();

    unified_mem_arbiter #(.BIT_COUNT(32), .WORD_SIZE(32), .MEM_LATENCY(1), .MAX_DATA_STREAK(4))
        dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    unified_mem_arbiter #(.BIT_COUNT(32), .WORD_SIZE(32), .MEM_LATENCY(3), .MAX_DATA_STREAK(4))
        dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

    logic [31:0] mem1 [64];
    logic [31:0] mem3 [64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus1.MemReadData = mem1[bus1.MemAdr[7:2]];
    assign bus3.MemReadData = mem3[bus3.MemAdr[7:2]];

    // Memory models: preloaded on reset, byte-enabled write on the rising edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) begin
                mem1[i] <= 32'h0;
                mem3[i] <= 32'h0;
            end
            mem1[2] <= 32'h00A00093;
            mem3[4] <= 32'h12345678;
            mem3[5] <= 32'hCAFEF00D;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (bus1.MemEn && bus1.MemWrite && bus1.MemByteEn[b])
                    mem1[bus1.MemAdr[7:2]][8*b +: 8] <= bus1.MemWriteData[8*b +: 8];
                if (bus3.MemEn && bus3.MemWrite && bus3.MemByteEn[b])
                    mem3[bus3.MemAdr[7:2]][8*b +: 8] <= bus3.MemWriteData[8*b +: 8];
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        bus1.DReq = 1'b1; bus1.IReq = 1'b1;
        #2;
        checks++; if (bus1.DReady !== 1'b0) begin errors++; $display("FAIL reset_dready: got %b want 0", bus1.DReady); end
        checks++; if (bus1.IReady !== 1'b0) begin errors++; $display("FAIL reset_iready: got %b want 0", bus1.IReady); end
        checks++; if (bus1.IValid !== 1'b0 || bus1.DValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b%b want 00", bus1.IValid, bus1.DValid); end
        checks++; if (bus1.IData !== 32'h0 || bus1.DData !== 32'h0) begin errors++; $display("FAIL reset_data: got %h %h want 0 0", bus1.IData, bus1.DData); end
        checks++; if ({bus1.MemEn, bus1.MemWrite, bus1.MemByteEn, bus1.MemAdr, bus1.MemWriteData} !== '0) begin errors++; $display("FAIL reset_mem: got en=%b we=%b adr=%h want all 0", bus1.MemEn, bus1.MemWrite, bus1.MemAdr); end
        @(negedge clk);
        bus1.DReq = 1'b0; bus1.IReq = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_single_fetch();
        @(negedge clk); bus1.IReq = 1'b1; bus1.IAdr = 32'h8; #1;
        checks++; if (bus1.IReady !== 1'b1) begin errors++; $display("FAIL fetch_iready: got %b want 1", bus1.IReady); end
        checks++; if (bus1.DReady !== 1'b0) begin errors++; $display("FAIL fetch_dready: got %b want 0", bus1.DReady); end
        @(negedge clk); bus1.IReq = 1'b0; #1;
        checks++; if (bus1.MemEn !== 1'b1 || bus1.MemAdr !== 32'h8) begin errors++; $display("FAIL fetch_mem: got en=%b adr=%h want 1 00000008", bus1.MemEn, bus1.MemAdr); end
        checks++; if (bus1.MemByteEn !== 4'h0 || bus1.MemWrite !== 1'b0) begin errors++; $display("FAIL fetch_mem_be: got be=%h we=%b want 0 0", bus1.MemByteEn, bus1.MemWrite); end
        checks++; if (bus1.IValid !== 1'b0) begin errors++; $display("FAIL fetch_early_valid: got %b want 0", bus1.IValid); end
        @(negedge clk); #1;
        checks++; if (bus1.IValid !== 1'b1 || bus1.IData !== 32'h00A00093) begin errors++; $display("FAIL fetch_resp: got v=%b d=%h want 1 00a00093", bus1.IValid, bus1.IData); end
        checks++; if (bus1.DValid !== 1'b0 || bus1.MemEn !== 1'b0) begin errors++; $display("FAIL fetch_resp_side: got dv=%b en=%b want 0 0", bus1.DValid, bus1.MemEn); end
        @(negedge clk); #1;
        checks++; if (bus1.IValid !== 1'b0 || bus1.IData !== 32'h00A00093) begin errors++; $display("FAIL fetch_pulse_hold: got v=%b d=%h want 0 00a00093", bus1.IValid, bus1.IData); end
    endtask

    task automatic test_store_load();
        @(negedge clk);
        bus1.DReq = 1'b1; bus1.DWrite = 1'b1; bus1.DAdr = 32'h4;
        bus1.DWriteData = 32'hDEADBEEF; bus1.DByteEn = 4'hF; #1;
        checks++; if (bus1.DReady !== 1'b1) begin errors++; $display("FAIL store_dready: got %b want 1", bus1.DReady); end
        @(negedge clk); bus1.DReq = 1'b0; #1;
        checks++; if (bus1.MemWrite !== 1'b1 || bus1.MemAdr !== 32'h4 || bus1.MemByteEn !== 4'hF) begin errors++; $display("FAIL store_mem: got we=%b adr=%h be=%h want 1 00000004 f", bus1.MemWrite, bus1.MemAdr, bus1.MemByteEn); end
        checks++; if (bus1.MemWriteData !== 32'hDEADBEEF) begin errors++; $display("FAIL store_wdata: got %h want deadbeef", bus1.MemWriteData); end
        @(negedge clk);
        checks++; if (bus1.DValid !== 1'b1 || bus1.DData !== 32'h0) begin errors++; $display("FAIL store_ack: got v=%b d=%h want 1 00000000", bus1.DValid, bus1.DData); end
        checks++; if (bus1.MemWrite !== 1'b0) begin errors++; $display("FAIL store_we_once: got %b want 0", bus1.MemWrite); end
        // Load issued in the RESP cycle of the store
        bus1.DReq = 1'b1; bus1.DWrite = 1'b0; bus1.DWriteData = 32'h11111111; #1;
        checks++; if (bus1.DReady !== 1'b1) begin errors++; $display("FAIL load_dready_in_resp: got %b want 1", bus1.DReady); end
        @(negedge clk); bus1.DReq = 1'b0; #1;
        checks++; if (bus1.MemWrite !== 1'b0 || bus1.MemWriteData !== 32'h0) begin errors++; $display("FAIL load_mem: got we=%b wd=%h want 0 00000000", bus1.MemWrite, bus1.MemWriteData); end
        @(negedge clk); #1;
        checks++; if (bus1.DValid !== 1'b1 || bus1.DData !== 32'hDEADBEEF) begin errors++; $display("FAIL load_resp: got v=%b d=%h want 1 deadbeef", bus1.DValid, bus1.DData); end
    endtask

    task automatic test_contention();
        logic [9:0] expI;
        int grants;
        expI = 10'b10_0001_0000;   // grant k is a fetch when bit k is set
        grants = 0;
        @(negedge clk);
        bus1.IReq = 1'b1; bus1.IAdr = 32'h8;
        bus1.DReq = 1'b1; bus1.DWrite = 1'b0; bus1.DAdr = 32'h4;
        for (int cyc = 0; cyc < 40 && grants < 10; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            checks++; if (bus1.IReady === 1'b1 && bus1.DReady === 1'b1) begin errors++; $display("FAIL contend_both_ready: got 11 want at most one"); end
            if (bus1.IReady === 1'b1 || bus1.DReady === 1'b1) begin
                checks++;
                if (bus1.IReady !== expI[grants]) begin
                    errors++;
                    $display("FAIL contend_order grant %0d: got %s want %s", grants, bus1.IReady ? "I" : "D", expI[grants] ? "I" : "D");
                end
                grants++;
            end
        end
        checks++; if (grants != 10) begin errors++; $display("FAIL contend_timeout: got %0d grants want 10", grants); end
        @(negedge clk); bus1.IReq = 1'b0; bus1.DReq = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back_latency3();
        @(negedge clk);
        bus3.DReq = 1'b1; bus3.DWrite = 1'b0; bus3.DAdr = 32'h10; bus3.DByteEn = 4'hF; #1;
        checks++; if (bus3.DReady !== 1'b1) begin errors++; $display("FAIL lat3_dready: got %b want 1", bus3.DReady); end
        @(negedge clk); bus3.DReq = 1'b0; bus3.IReq = 1'b1; bus3.IAdr = 32'h14;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            checks++; if (bus3.MemEn !== 1'b1 || bus3.MemAdr !== 32'h10 || bus3.MemWrite !== 1'b0) begin errors++; $display("FAIL lat3_hold c%0d: got en=%b adr=%h we=%b want 1 00000010 0", c, bus3.MemEn, bus3.MemAdr, bus3.MemWrite); end
            checks++; if (bus3.DValid !== 1'b0 || bus3.IReady !== 1'b0) begin errors++; $display("FAIL lat3_busy c%0d: got dv=%b ir=%b want 0 0", c, bus3.DValid, bus3.IReady); end
        end
        @(negedge clk); #1;
        checks++; if (bus3.DValid !== 1'b1 || bus3.DData !== 32'h12345678) begin errors++; $display("FAIL lat3_resp: got v=%b d=%h want 1 12345678", bus3.DValid, bus3.DData); end
        checks++; if (bus3.IReady !== 1'b1) begin errors++; $display("FAIL lat3_b2b_accept: got %b want 1", bus3.IReady); end
        @(negedge clk); bus3.IReq = 1'b0; #1;
        checks++; if (bus3.MemEn !== 1'b1 || bus3.MemAdr !== 32'h14 || bus3.DValid !== 1'b0) begin errors++; $display("FAIL lat3_b2b_mem: got en=%b adr=%h dv=%b want 1 00000014 0", bus3.MemEn, bus3.MemAdr, bus3.DValid); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus3.IValid !== 1'b1 || bus3.IData !== 32'hCAFEF00D) begin errors++; $display("FAIL lat3_b2b_resp: got v=%b d=%h want 1 cafef00d", bus3.IValid, bus3.IData); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_store();
        @(negedge clk);
        bus3.DReq = 1'b1; bus3.DWrite = 1'b1; bus3.DAdr = 32'h20;
        bus3.DWriteData = 32'h55AA55AA; bus3.DByteEn = 4'hF; #1;
        checks++; if (bus3.DReady !== 1'b1) begin errors++; $display("FAIL rst_store_dready: got %b want 1", bus3.DReady); end
        @(negedge clk); bus3.DReq = 1'b0; #1;
        checks++; if (bus3.MemEn !== 1'b1 || bus3.MemWrite !== 1'b0) begin errors++; $display("FAIL rst_store_access: got en=%b we=%b want 1 0", bus3.MemEn, bus3.MemWrite); end
        @(negedge clk);
        reset = 1'b0; bus3.DReq = 1'b1; #1;
        checks++; if ({bus3.MemEn, bus3.MemWrite, bus3.MemByteEn, bus3.MemAdr, bus3.MemWriteData} !== '0) begin errors++; $display("FAIL rst_async_mem: got en=%b we=%b adr=%h want all 0", bus3.MemEn, bus3.MemWrite, bus3.MemAdr); end
        checks++; if (bus3.DValid !== 1'b0 || bus3.DReady !== 1'b0 || bus3.DData !== 32'h0) begin errors++; $display("FAIL rst_async_out: got dv=%b dr=%b dd=%h want 0 0 0", bus3.DValid, bus3.DReady, bus3.DData); end
        @(negedge clk); bus3.DReq = 1'b0; reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            checks++; if (bus3.MemWrite !== 1'b0 || bus3.DValid !== 1'b0 || bus3.MemEn !== 1'b0) begin errors++; $display("FAIL rst_discard c%0d: got we=%b dv=%b en=%b want 0 0 0", c, bus3.MemWrite, bus3.DValid, bus3.MemEn); end
        end
        checks++; if (mem3[8] !== 32'h0) begin errors++; $display("FAIL rst_no_write: got %h want 00000000", mem3[8]); end
        // A fresh fetch after reset completes normally
        @(negedge clk); bus3.IReq = 1'b1; bus3.IAdr = 32'h14; #1;
        checks++; if (bus3.IReady !== 1'b1) begin errors++; $display("FAIL rst_fresh_iready: got %b want 1", bus3.IReady); end
        @(negedge clk); bus3.IReq = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus3.IValid !== 1'b1 || bus3.IData !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_fresh_resp: got v=%b d=%h want 1 cafef00d", bus3.IValid, bus3.IData); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_req_withdrawn();
        @(negedge clk); bus1.IReq = 1'b1; bus1.IAdr = 32'h8; #1;
        checks++; if (bus1.IReady !== 1'b1) begin errors++; $display("FAIL wd_iready: got %b want 1", bus1.IReady); end
        @(negedge clk);
        bus1.IReq = 1'b0; bus1.DReq = 1'b1; bus1.DWrite = 1'b1; bus1.DAdr = 32'h4; #1;
        checks++; if (bus1.DReady !== 1'b0 || bus1.MemAdr !== 32'h8) begin errors++; $display("FAIL wd_busy: got dr=%b adr=%h want 0 00000008", bus1.DReady, bus1.MemAdr); end
        @(negedge clk); bus1.DReq = 1'b0; #1;
        checks++; if (bus1.IValid !== 1'b1 || bus1.DReady !== 1'b0) begin errors++; $display("FAIL wd_resp: got iv=%b dr=%b want 1 0", bus1.IValid, bus1.DReady); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++; if (bus1.MemEn !== 1'b0 || bus1.DValid !== 1'b0) begin errors++; $display("FAIL wd_no_access c%0d: got en=%b dv=%b want 0 0", c, bus1.MemEn, bus1.DValid); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus1.IReq = 1'b0; bus1.IAdr = '0; bus1.DReq = 1'b0; bus1.DWrite = 1'b0;
        bus1.DByteEn = '0; bus1.DAdr = '0; bus1.DWriteData = '0;
        bus3.IReq = 1'b0; bus3.IAdr = '0; bus3.DReq = 1'b0; bus3.DWrite = 1'b0;
        bus3.DByteEn = '0; bus3.DAdr = '0; bus3.DWriteData = '0;

        test_reset();
        test_single_fetch();
        test_store_load();
        test_contention();
        test_back_to_back_latency3();
        test_reset_mid_store();
        test_req_withdrawn();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory (vectorStorage-style: combinational read, write on WriteEnable) between the core's instruction-fetch port and its data port.
- Sits between computeCore and a single memory instance, replacing the split instruction/data memories.
- Sequences each access through an issue/hold/response FSM with valid/ready handshakes.
- Arbitrates with data priority plus an anti-starvation streak limit for fetch.

Parameters:
BIT_COUNT, 32, address width for both requesters and the memory.
WORD_SIZE, 32, data width; byte-enable width is WORD_SIZE/8.
MEM_LATENCY, 1, cycles memory inputs are held stable before read data is sampled (legal 1..4).
MAX_DATA_STREAK, 4, consecutive contested data grants after which fetch is forced to win.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
IReq  in  1  fetch request
IAdr  in  BIT_COUNT  fetch address
IReady  out  1  fetch request accepted this cycle
IValid  out  1  fetch data valid, 1-cycle pulse
IData  out  WORD_SIZE  fetched instruction, held until next fetch response
DReq  in  1  data request
DWrite  in  1  1 = store, 0 = load
DByteEn  in  WORD_SIZE/8  byte enables
DAdr  in  BIT_COUNT  data address
DWriteData  in  WORD_SIZE  store data
DReady  out  1  data request accepted this cycle
DValid  out  1  load data valid or store ack, 1-cycle pulse
DData  out  WORD_SIZE  load data, held until next load response
MemEn  out  1  memory enable
MemWrite  out  1  memory write enable
MemByteEn  out  WORD_SIZE/8  memory byte enables
MemAdr  out  BIT_COUNT  memory address
MemWriteData  out  WORD_SIZE  memory write data
MemReadData  in  WORD_SIZE  memory read data

Behaviour:
Reset:
- While reset=0, all registers clear immediately: state IDLE, streak 0, IValid=DValid=0, IData=DData=0, all Mem* outputs 0.
- IReady and DReady are forced 0 during reset.
- Reset mid-transaction discards the in-flight access: no Valid pulse and no further MemWrite.

FSM states: IDLE, ACCESS, RESP. Only one transaction is outstanding at a time.

Accept:
- Accept is allowed only in IDLE or RESP.
- Ready is combinational from Req, state and streak. At most one Ready per cycle.
- On accept, the request fields and an owner bit are registered, and the FSM goes to ACCESS with the hold counter set to MEM_LATENCY-1.

Arbitration when both IReq and DReq are high:
- DReady wins unless streak == MAX_DATA_STREAK; then IReady wins.

Streak counter:
- Increments, saturating, on a data grant while IReq=1.
- Clears on any fetch grant, or on a data grant while IReq=0.

Requester rules:
- Req and its fields must stay stable until Ready.
- Deasserting Req before Ready is legal; the request is simply not accepted.

ACCESS:
- Mem* are driven from the registered request.
- MemEn=1. MemAdr = latched address. MemWriteData = latched data for a store, else 0.
- MemByteEn = latched DByteEn for data, 0 for fetch.
- MemWrite=1 only on the final ACCESS cycle of a store.
- The counter decrements each cycle. When it reaches 0: MemReadData is captured into IData (fetch) or DData (load; DData is unchanged on a store), and the FSM goes to RESP.

RESP:
- The owner's Valid=1 for exactly one cycle; Mem* return to 0.
- If a request is accepted in RESP, go to ACCESS; otherwise go to IDLE.

Timing:
- Latency from accept to Valid is MEM_LATENCY+1 cycles.
- Peak throughput is one transaction per MEM_LATENCY+1 cycles.

Test Plan:
- Single fetch, MEM_LATENCY=1, memory word at address 0x8 = 0x00A00093: IReq with IAdr=0x8 -> IReady at c0, MemEn=1 with MemAdr=0x8 at c1, IValid=1 with IData=0x00A00093 at c2; DValid stays 0.
- Store then load to 0x4: store DWriteData=0xDEADBEEF, DByteEn=4'hF -> MemWrite=1 for one cycle, DValid ack, DData unchanged; following load -> DData=0xDEADBEEF.
- Contention, MAX_DATA_STREAK=4: IReq and DReq held high continuously -> grant order D,D,D,D,I,D,D,D,D,I; no fetch waits more than 4 data grants.
- MEM_LATENCY=3, load from 0x10: MemEn and MemAdr=0x10 held for 3 cycles, MemWrite never 1, DValid 4 cycles after DReady; back-to-back accept occurs in the RESP cycle.
- Reset pulse (reset=0) during ACCESS of a store -> MemWrite never asserts, all outputs 0 immediately and asynchronously; after release, a fresh fetch completes normally.
- Req withdrawn: DReq high for one cycle while a fetch is in ACCESS, then dropped -> no DReady, no data access issued.
